// File: rtl/except_arb_pkg.sv
// Shared definitions for the exception arbiter: ExcCodes, exc_src bit map,
// FSM state encoding and the captured-exception record.
package except_arb_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;
  localparam int unsigned SRC_W = 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [EXC_W-1:0] EXCC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXCC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXCC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXCC_SYS  = 5'd8;
  localparam logic [EXC_W-1:0] EXCC_BP   = 5'd9;
  localparam logic [EXC_W-1:0] EXCC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXCC_OV   = 5'd12;

  // Bit positions inside exc_src; bit 0 is reserved.
  localparam int unsigned SRC_ADES_D = 7;
  localparam int unsigned SRC_ADEL_D = 6;
  localparam int unsigned SRC_SY     = 5;
  localparam int unsigned SRC_BP     = 4;
  localparam int unsigned SRC_OV     = 3;
  localparam int unsigned SRC_RI     = 2;
  localparam int unsigned SRC_ADEL_I = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  epc;
    logic [XLEN-1:0]  bva;
    logic [EXC_W-1:0] code;
    logic             bd;
    logic             is_eret;
  } exc_rec_t;

endpackage

// File: rtl/except_arb_prio.sv
// Combinational priority encoder: picks the single event taken this cycle.
module except_prio
  import except_arb_pkg::*;
(
  input  logic             en_i,
  input  logic             int_pend_i,
  input  logic             valid_i,
  input  logic [SRC_W-1:0] exc_src_i,
  input  logic             er_i,
  output logic             take_o,
  output logic [EXC_W-1:0] code_o,
  output logic             is_eret_o
);

  logic unused_ok;
  assign unused_ok = exc_src_i[0];

  // Interrupts ignore valid; synchronous sources and ERET need a real instruction.
  always_comb begin
    take_o    = 1'b0;
    code_o    = EXCC_INT;
    is_eret_o = 1'b0;
    if (en_i) begin
      if (int_pend_i) begin
        take_o = 1'b1;
        code_o = EXCC_INT;
      end else if (valid_i) begin
        if (exc_src_i[SRC_ADEL_I]) begin
          take_o = 1'b1;
          code_o = EXCC_ADEL;
        end else if (exc_src_i[SRC_RI]) begin
          take_o = 1'b1;
          code_o = EXCC_RI;
        end else if (exc_src_i[SRC_OV]) begin
          take_o = 1'b1;
          code_o = EXCC_OV;
        end else if (exc_src_i[SRC_BP]) begin
          take_o = 1'b1;
          code_o = EXCC_BP;
        end else if (exc_src_i[SRC_SY]) begin
          take_o = 1'b1;
          code_o = EXCC_SYS;
        end else if (exc_src_i[SRC_ADEL_D]) begin
          take_o = 1'b1;
          code_o = EXCC_ADEL;
        end else if (exc_src_i[SRC_ADES_D]) begin
          take_o = 1'b1;
          code_o = EXCC_ADES;
        end else if (er_i) begin
          take_o    = 1'b1;
          is_eret_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/except_arb.sv
// MM-stage exception/interrupt/ERET arbiter: picks one event, waits for the
// data bus to drain, then squashes the pipeline and redirects fetch.
module except_arb
  import except_arb_pkg::*;
#(
  parameter int unsigned     N_INT        = 8,
  parameter logic [XLEN-1:0] EXC_VECTOR   = 32'hbfc00380,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             slot,
  input  logic [XLEN-1:0]  pc,
  input  logic [N_INT-1:0] intr_vect,
  input  logic [N_INT-1:0] intr_mask,
  input  logic             ie,
  input  logic             exl,
  input  logic [SRC_W-1:0] exc_src,
  input  logic [XLEN-1:0]  bad_addr_i,
  input  logic [XLEN-1:0]  bad_addr_d,
  input  logic             er,
  input  logic [XLEN-1:0]  er_epc,
  input  logic             mem_busy,
  output logic             stall,
  output logic             flush,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_addr,
  output logic             cp0_we,
  output logic             cp0_bd,
  output logic [EXC_W-1:0] cp0_exc,
  output logic [XLEN-1:0]  cp0_epc,
  output logic [XLEN-1:0]  cp0_bva
);

  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  exc_rec_t         rec_q, rec_d;

  logic             int_pend;
  logic             take;
  logic [EXC_W-1:0] take_code;
  logic             take_eret;
  logic             first_flush;
  exc_rec_t         rec_new;

  assign int_pend = (|(intr_vect & intr_mask)) & ie & ~exl;

  except_prio u_prio (
    .en_i       (state_q == ST_IDLE && !rst),
    .int_pend_i (int_pend),
    .valid_i    (valid),
    .exc_src_i  (exc_src),
    .er_i       (er),
    .take_o     (take),
    .code_o     (take_code),
    .is_eret_o  (take_eret)
  );

  // Record captured at the take; an ADEL with adel_i set can only be the fetch fault.
  always_comb begin
    rec_new         = '0;
    rec_new.code    = take_code;
    rec_new.is_eret = take_eret;
    rec_new.bd      = slot;
    rec_new.epc     = slot ? (pc - 32'd4) : pc;
    rec_new.target  = take_eret ? er_epc : EXC_VECTOR;
    if (take_code == EXCC_ADEL && exc_src[SRC_ADEL_I]) begin
      rec_new.bva = bad_addr_i;
    end else if (take_code == EXCC_ADEL || take_code == EXCC_ADES) begin
      rec_new.bva = bad_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rec_d   = rec_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          rec_d   = rec_new;
          cnt_d   = '0;
          state_d = mem_busy ? ST_DRAIN : ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        if (!mem_busy) begin
          cnt_d   = '0;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rec_q   <= rec_d;
    end
  end

  assign first_flush = (state_q == ST_FLUSH) && (cnt_q == '0);

  always_comb begin
    stall         = take || (state_q != ST_IDLE);
    flush         = (state_q == ST_FLUSH);
    redirect      = first_flush;
    redirect_addr = first_flush ? rec_q.target : '0;
    cp0_we        = first_flush && !rec_q.is_eret;
    cp0_bd        = rec_q.bd;
    cp0_exc       = rec_q.code;
    cp0_epc       = rec_q.epc;
    cp0_bva       = rec_q.bva;
  end

endmodule
